game_turn_scheduler: RTL and testbench
======================================

Name: game_turn_scheduler

Overview:
Sequences the 64x64 light-cycle grid datapath once per game step. Holds both players' positions and headings, and time-multiplexes the grid's single position/enable interface between player 1 and player 2. Collects the grid's exception flags and declares game over with a winner code. Sits between the input-decode logic and the grid; its play_x, play_y, play_num and super_enable outputs drive the grid directly.

Parameters:
TICK_DIV, 500000, clock cycles per game step; minimum 16.
SETTLE_CYC, 2, cycles to wait after each player issue before sampling exc_in; range 1..7.
P1_START_X, 8, player 1 reset/start x.
P1_START_Y, 32, player 1 reset/start y.
P2_START_X, 55, player 2 reset/start x.
P2_START_Y, 32, player 2 reset/start y.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  level/pulse; begins a game from IDLE
dir1  in  2  player 1 heading request: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1)
dir1_valid  in  1  qualifies dir1
dir2  in  2  player 2 heading request, same encoding
dir2_valid  in  1  qualifies dir2
exc_in  in  5  grid exception bus: [0] any event, [1] player-1 wall hit, [2] any wall hit, [4] head-on crash
play_x  out  32  grid x; bits [31:6] are always 0
play_y  out  32  grid y; bits [31:6] are always 0
play_num  out  1  0 = player 1 slot, 1 = player 2 slot
super_enable  out  1  one-cycle write strobe to the grid
game_over  out  1  high from OVER entry until start or reset
winner  out  2  00 none, 01 player 1 wins, 10 player 2 wins, 11 draw
state_out  out  3  current FSM state encoding
step_count  out  16  completed steps in the current game; saturates at 16'hFFFF

Behaviour:
- Reset values:
  - all outputs 0 except play_x = P1_START_X, play_y = P1_START_Y.
  - heading1 = 01 (right), heading2 = 11 (left).
  - tick counter cleared; FSM in IDLE.
- FSM encodings: IDLE=0, WAIT_TICK=1, ISSUE_P1=2, SETTLE_P1=3, ISSUE_P2=4, SETTLE_P2=5, CHECK=6, OVER=7.
- IDLE: on start=1, load start positions and default headings, clear step_count, winner and the sticky flags, then go to WAIT_TICK. A start received in any other state except OVER is ignored.
- WAIT_TICK:
  - the tick counter counts 0..TICK_DIV-1.
  - at terminal count it resets to 0, and each player's pending heading is committed to its active heading.
  - each player's next position is computed from the committed heading, then the FSM goes to ISSUE_P1.
- Heading requests:
  - a valid request is stored as pending in any state.
  - a request that reverses the current active heading (xor == 2'b10) is discarded.
  - if the same player has several valid requests in one step, the last one wins.
- ISSUE_P1: play_num=0, play_x/play_y = player 1's next position, super_enable=1 for exactly this cycle. Go to SETTLE_P1.
- SETTLE_P1:
  - super_enable=0; play_x, play_y and play_num are held.
  - stays SETTLE_CYC cycles; exc_in is sampled every cycle and OR-ed into sticky flags f1 (exc_in[1]), fw (exc_in[2]) and fc (exc_in[4]).
  - then go to ISSUE_P2.
- ISSUE_P2 / SETTLE_P2: identical to ISSUE_P1 / SETTLE_P1 with play_num=1 and player 2's next position; then go to CHECK.
- CHECK (one cycle), evaluated in priority order:
  - fc, or f1 together with (fw with player 2 also flagged) → winner=11.
  - f1 only → winner=10.
  - fw & ~f1 → winner=01.
  - any of the above → OVER. Otherwise step_count increments (saturating) and the FSM returns to WAIT_TICK.
  - player 2 is flagged during SETTLE_P2 by exc_in[2] & ~exc_in[1].
  - if both players are flagged in the same step, the result is a draw (11).
- OVER: game_over=1, winner held, super_enable=0. On start, take the IDLE start actions and go to WAIT_TICK. reset always wins.
- Position arithmetic: 6-bit, modulo 64; 0-1 wraps to 63 and 63+1 wraps to 0 (when ARENA_WRAP_EN is defined).
- Reset mid-operation is asynchronous: the FSM returns to IDLE immediately and super_enable drops the same cycle.

Optional Feature:
ARENA_WRAP_EN
- Defined: positions wrap modulo 64 as above.
- Undefined: a move off any edge is never issued to the grid. The ISSUE cycle for that player is skipped (super_enable stays 0) and the player is flagged as crashed.
- With the feature undefined, CHECK resolves edge crashes with the same priority rules as wall hits.

Test Plan:
- Reset, then start with TICK_DIV=16 and no exc → the first super_enable pulse comes 16 cycles after WAIT_TICK entry with play_num=0 at (9,32), then play_num=1 at (54,32); step_count=1 after CHECK.
- dir1=00 valid during WAIT_TICK → the next player-1 issue is at (x,31). A dir1=11 request while heading right is discarded and the heading stays right.
- Player 1 at x=63 heading right with wrap enabled → issues x=0. With the macro undefined, no strobe is issued and winner=10, game_over=1.
- exc_in=5'b00110 during SETTLE_P1 → winner=10, OVER; a later start restarts with step_count=0 and winner=00.
- exc_in=5'b10001 during SETTLE_P2 → winner=11. Player-1 wall flag plus player-2 wall flag in the same step → winner=11.
- Assert reset during SETTLE_P2 → state_out=0 and super_enable=0 asynchronously; outputs return to their reset values.

Source files
------------

// File: rtl/game_turn_scheduler.sv
// Steps the two-player light-cycle game. Issues each player's move to the grid, collects the grid's exception flags and declares the winner.
// Latency: a step takes TICK_DIV + 2*(1+SETTLE_CYC) + 1 cycles. Requests are stored at any time and take effect at the next tick.
// No backpressure. Optional edge wrap is enabled by defining ARENA_WRAP_EN; when it is undefined, leaving the arena counts as a crash.
module game_turn_scheduler #(
    parameter int TICK_DIV   = 500000,
    parameter int SETTLE_CYC = 2,
    parameter int P1_START_X = 8,
    parameter int P1_START_Y = 32,
    parameter int P2_START_X = 55,
    parameter int P2_START_Y = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  dir1,
    input  logic        dir1_valid,
    input  logic [1:0]  dir2,
    input  logic        dir2_valid,
    input  logic [4:0]  exc_in,
    output logic [31:0] play_x,
    output logic [31:0] play_y,
    output logic        play_num,
    output logic        super_enable,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [2:0]  state_out,
    output logic [15:0] step_count
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [2:0]    SETTLE_LAST = 3'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TICK = 3'd1,
        ST_ISSUE_P1  = 3'd2,
        ST_SETTLE_P1 = 3'd3,
        ST_ISSUE_P2  = 3'd4,
        ST_SETTLE_P2 = 3'd5,
        ST_CHECK     = 3'd6,
        ST_OVER      = 3'd7
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   tick_cnt;
    logic [2:0]      settle_cnt;
    logic [5:0]      p1x, p1y, p2x, p2y;
    logic [1:0]      head1, head2, pend1, pend2;
    logic            f1, fw, fc, f2, e1, e2;
    logic [12:0]     mv1, mv2;
    logic            tick_done, settle_done, start_go;
    logic            hit1, hit2, draw, crash;
    logic [1:0]      win_code;
    logic            unused_exc;

    // Returns {off_edge, x, y} for one move; off_edge is never set when the arena wraps.
    function automatic logic [12:0] move(input logic [5:0] x, input logic [5:0] y,
                                         input logic [1:0] h);
        logic [5:0] nx, ny;
        logic       off;
        nx  = x;
        ny  = y;
        off = 1'b0;
        case (h)
            2'b00: begin ny = y - 6'd1; off = (y == 6'd0);  end
            2'b01: begin nx = x + 6'd1; off = (x == 6'd63); end
            2'b10: begin ny = y + 6'd1; off = (y == 6'd63); end
            default: begin nx = x - 6'd1; off = (x == 6'd0); end
        endcase
`ifdef ARENA_WRAP_EN
        off = 1'b0;
`endif
        return {off, nx, ny};
    endfunction

    assign mv1         = move(p1x, p1y, pend1);
    assign mv2         = move(p2x, p2y, pend2);
    assign tick_done   = (tick_cnt == TICK_LAST);
    assign settle_done = (settle_cnt == SETTLE_LAST);
    assign start_go    = start && (state == ST_IDLE || state == ST_OVER);
    assign unused_exc  = ^{exc_in[0], exc_in[3]};

    // An edge crash is treated exactly like a wall hit for the player concerned.
    assign hit1     = f1 | e1;
    assign hit2     = f2 | e2;
    assign draw     = fc | (hit1 & hit2);
    assign crash    = draw | hit1 | fw | e2;
    assign win_code = draw ? 2'b11 : hit1 ? 2'b10 : 2'b01;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (start) state_nxt = ST_WAIT_TICK;
            ST_WAIT_TICK: if (tick_done) state_nxt = ST_ISSUE_P1;
            ST_ISSUE_P1:  state_nxt = ST_SETTLE_P1;
            ST_SETTLE_P1: if (settle_done) state_nxt = ST_ISSUE_P2;
            ST_ISSUE_P2:  state_nxt = ST_SETTLE_P2;
            ST_SETTLE_P2: if (settle_done) state_nxt = ST_CHECK;
            ST_CHECK:     state_nxt = crash ? ST_OVER : ST_WAIT_TICK;
            default:      if (start) state_nxt = ST_WAIT_TICK;
        endcase
    end

    always_comb begin
        super_enable = 1'b0;
        play_num     = 1'b0;
        play_x       = {26'd0, p1x};
        play_y       = {26'd0, p1y};
        game_over    = (state == ST_OVER);
        state_out    = state;
        case (state)
            ST_ISSUE_P1: super_enable = ~e1;
            ST_ISSUE_P2: begin
                super_enable = ~e2;
                play_num     = 1'b1;
                play_x       = {26'd0, p2x};
                play_y       = {26'd0, p2y};
            end
            ST_SETTLE_P2: begin
                play_num = 1'b1;
                play_x   = {26'd0, p2x};
                play_y   = {26'd0, p2y};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt   <= '0;
            settle_cnt <= '0;
            p1x        <= 6'(P1_START_X);
            p1y        <= 6'(P1_START_Y);
            p2x        <= 6'(P2_START_X);
            p2y        <= 6'(P2_START_Y);
            head1      <= 2'b01;
            pend1      <= 2'b01;
            head2      <= 2'b11;
            pend2      <= 2'b11;
            {f1, fw, fc, f2, e1, e2} <= '0;
            winner     <= 2'b00;
            step_count <= 16'd0;
        end else begin
            // Reversals are judged against the heading currently in force.
            if (dir1_valid && ((dir1 ^ head1) != 2'b10)) pend1 <= dir1;
            if (dir2_valid && ((dir2 ^ head2) != 2'b10)) pend2 <= dir2;
            if (start_go) begin
                tick_cnt   <= '0;
                settle_cnt <= '0;
                p1x        <= 6'(P1_START_X);
                p1y        <= 6'(P1_START_Y);
                p2x        <= 6'(P2_START_X);
                p2y        <= 6'(P2_START_Y);
                head1      <= 2'b01;
                pend1      <= 2'b01;
                head2      <= 2'b11;
                pend2      <= 2'b11;
                {f1, fw, fc, f2, e1, e2} <= '0;
                winner     <= 2'b00;
                step_count <= 16'd0;
            end else begin
                case (state)
                    ST_WAIT_TICK: begin
                        if (tick_done) begin
                            tick_cnt <= '0;
                            head1    <= pend1;
                            head2    <= pend2;
                            e1       <= mv1[12];
                            e2       <= mv2[12];
                            if (!mv1[12]) {p1x, p1y} <= mv1[11:0];
                            if (!mv2[12]) {p2x, p2y} <= mv2[11:0];
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    ST_SETTLE_P1, ST_SETTLE_P2: begin
                        settle_cnt <= settle_done ? 3'd0 : settle_cnt + 3'd1;
                        f1 <= f1 | exc_in[1];
                        fw <= fw | exc_in[2];
                        fc <= fc | exc_in[4];
                        if (state == ST_SETTLE_P2) f2 <= f2 | (exc_in[2] & ~exc_in[1]);
                    end
                    ST_CHECK: begin
                        if (crash)                       winner     <= win_code;
                        else if (step_count != 16'hFFFF) step_count <= step_count + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_game_turn_scheduler.sv
// Randomized bench for game_turn_scheduler against a step/phase model, plus directed literal checks.
module tb_game_turn_scheduler;
    localparam int T = 16;
    localparam int S = 2;

    logic        clock = 1'b0;
    logic        reset, start, dir1_valid, dir2_valid;
    logic [1:0]  dir1, dir2;
    logic [4:0]  exc_in;
    logic [31:0] play_x, play_y;
    logic        play_num, super_enable, game_over;
    logic [1:0]  winner;
    logic [2:0]  state_out;
    logic [15:0] step_count;

    int n_vec = 0;
    int n_err = 0;

    game_turn_scheduler #(.TICK_DIV(T), .SETTLE_CYC(S)) dut (
        .clock(clock), .reset(reset), .start(start),
        .dir1(dir1), .dir1_valid(dir1_valid), .dir2(dir2), .dir2_valid(dir2_valid),
        .exc_in(exc_in), .play_x(play_x), .play_y(play_y), .play_num(play_num),
        .super_enable(super_enable), .game_over(game_over), .winner(winner),
        .state_out(state_out), .step_count(step_count)
    );

    always #5 clock = ~clock;

    // Model: mode 0 idle, 1 running, 2 over; ph is the cycle index within the current step.
    int       mode, ph, p1x, p1y, p2x, p2y, steps, win;
    bit [1:0] a1, q1, a2, q2;
    bit       f1, fw, fc, f2, e1, e2;
    int       dx[4] = '{0, 1, 0, -1};
    int       dy[4] = '{-1, 0, 1, 0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired at %0t", nm, $time);
    endtask

    function automatic void model_init();
        p1x = 8; p1y = 32; p2x = 55; p2y = 32;
        a1 = 2'b01; q1 = 2'b01; a2 = 2'b11; q2 = 2'b11;
        {f1, fw, fc, f2, e1, e2} = '0;
        steps = 0; win = 0; ph = 0;
    endfunction

    function automatic int cur_state();
        if (mode == 0) return 0;
        if (mode == 2) return 7;
        if (ph < T) return 1;
        if (ph == T) return 2;
        if (ph <= T + S) return 3;
        if (ph == T + S + 1) return 4;
        if (ph <= T + 2 * S + 1) return 5;
        return 6;
    endfunction

    function automatic void mv(input int x, input int y, input bit [1:0] h,
                               output int nx, output int ny, output bit eg);
        nx = x + dx[h];
        ny = y + dy[h];
`ifdef ARENA_WRAP_EN
        eg = 1'b0;
        nx = (nx + 64) % 64;
        ny = (ny + 64) % 64;
`else
        eg = (nx < 0 || nx > 63 || ny < 0 || ny > 63);
        if (eg) begin nx = x; ny = y; end
`endif
    endfunction

    function automatic void model_step(input bit s, input bit [1:0] d1, input bit v1,
                                       input bit [1:0] d2, input bit v2, input bit [4:0] e);
        int st, nx, ny, w;
        bit eg, h1, h2;
        bit [1:0] o1, o2;
        st = cur_state();
        o1 = q1; o2 = q2;
        if (v1 && ((d1 ^ a1) != 2'b10)) q1 = d1;
        if (v2 && ((d2 ^ a2) != 2'b10)) q2 = d2;
        if (mode != 1) begin
            if (s) begin model_init(); mode = 1; end
            return;
        end
        if (st == 1 && ph == T - 1) begin
            a1 = o1; a2 = o2;
            mv(p1x, p1y, o1, nx, ny, eg); p1x = nx; p1y = ny; e1 = eg;
            mv(p2x, p2y, o2, nx, ny, eg); p2x = nx; p2y = ny; e2 = eg;
        end
        if (st == 3 || st == 5) begin
            f1 |= e[1]; fw |= e[2]; fc |= e[4];
            if (st == 5) f2 |= e[2] & ~e[1];
        end
        if (st == 6) begin
            h1 = f1 | e1;
            h2 = f2 | e2;
            if (fc || (h1 && h2)) w = 3;
            else if (h1)          w = 2;
            else if (fw || e2)    w = 1;
            else                  w = 0;
            if (w != 0) begin mode = 2; win = w; end
            else begin
                if (steps < 65535) steps++;
                ph = 0;
            end
        end else begin
            ph++;
        end
    endfunction

    task automatic compare();
        int st;
        bit se, p2;
        st = cur_state();
        se = (st == 2 && !e1) || (st == 4 && !e2);
        p2 = (st == 4 || st == 5);
        chk("state_out", state_out, st);
        chk("super_enable", super_enable, se);
        chk("play_num", play_num, p2);
        chk("play_x", play_x, p2 ? p2x : p1x);
        chk("play_y", play_y, p2 ? p2y : p1y);
        chk("game_over", game_over, mode == 2);
        chk("winner", winner, win);
        chk("step_count", step_count, steps);
    endtask

    task automatic tick_cycle(input bit s, input bit [1:0] d1, input bit v1,
                              input bit [1:0] d2, input bit v2, input bit [4:0] e);
        @(negedge clock);
        compare();
        start = s; dir1 = d1; dir1_valid = v1; dir2 = d2; dir2_valid = v2; exc_in = e;
        model_step(s, d1, v1, d2, v2, e);
    endtask

    task automatic idle_tick();
        tick_cycle(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 5'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        start = 1'b0; dir1_valid = 1'b0; dir2_valid = 1'b0; exc_in = 5'd0;
        #1;
        chk("async_state", state_out, 0);
        chk("async_super_enable", super_enable, 0);
        mode = 0;
        model_init();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_strobe(input bit pn, output int px, output int py);
        bit seen = 1'b0;
        px = -1; py = -1;
        for (int k = 0; k < 100 && !seen; k++) begin
            idle_tick();
            if (super_enable === 1'b1 && play_num === pn) begin
                seen = 1'b1; px = play_x; py = play_y;
            end
        end
        if (!seen) bound_fail("wait_strobe");
    endtask

    task automatic wait_over();
        bit seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            idle_tick();
            if (game_over === 1'b1) seen = 1'b1;
        end
        if (!seen) bound_fail("wait_over");
    endtask

    initial begin
        int first, second, fx, fy, sx, sy, sc, x, y, n1, lx, ly;
        bit done;
        start = 0; dir1 = 0; dir1_valid = 0; dir2 = 0; dir2_valid = 0; exc_in = 0;
        reset = 1'b1;
        mode = 0;
        model_init();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("reset_state", state_out, 0);
        chk("reset_play_x", play_x, 8);
        chk("reset_play_y", play_y, 32);
        chk("reset_super_enable", super_enable, 0);

        // First step timing and positions.
        tick_cycle(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 5'd0);
        first = -1; second = -1; fx = 0; fy = 0; sx = 0; sy = 0; sc = -1;
        for (int k = 0; k < 30; k++) begin
            idle_tick();
            if (super_enable === 1'b1 && play_num === 1'b0 && first < 0) begin
                first = k; fx = play_x; fy = play_y;
            end
            if (super_enable === 1'b1 && play_num === 1'b1 && second < 0) begin
                second = k; sx = play_x; sy = play_y;
            end
            if (k == 24) sc = step_count;
        end
        chk("first_issue_cycle", first, 16);
        chk("first_issue_x", fx, 9);
        chk("first_issue_y", fy, 32);
        chk("second_issue_cycle", second, 19);
        chk("second_issue_x", sx, 54);
        chk("second_issue_y", sy, 32);
        chk("step_after_check", sc, 1);

        // Reversal discarded, then a turn up.
        tick_cycle(1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 5'd0);
        wait_strobe(1'b0, x, y);
        chk("reversal_x", x, 10);
        chk("reversal_y", y, 32);
        repeat (10) idle_tick();
        tick_cycle(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 5'd0);
        wait_strobe(1'b0, x, y);
        chk("turn_up_x", x, 10);
        chk("turn_up_y", y, 31);

        // Player 1 wall hit.
        tick_cycle(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 5'b00110);
        wait_over();
        chk("p1_wall_winner", winner, 2);
        tick_cycle(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 5'd0);
        idle_tick();
        chk("restart_steps", step_count, 0);
        chk("restart_winner", winner, 0);
        chk("restart_game_over", game_over, 0);

        // Head-on crash during player 2 settle.
        wait_strobe(1'b1, x, y);
        tick_cycle(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 5'b10001);
        wait_over();
        chk("headon_winner", winner, 3);

        // Both players hit walls in the same step.
        tick_cycle(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 5'd0);
        wait_strobe(1'b0, x, y);
        tick_cycle(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 5'b00110);
        wait_strobe(1'b1, x, y);
        tick_cycle(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 5'b00100);
        wait_over();
        chk("both_wall_winner", winner, 3);

        // Reset in the middle of player 2 settle.
        tick_cycle(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 5'd0);
        wait_strobe(1'b1, x, y);
        do_reset();
        chk("midreset_play_x", play_x, 8);
        chk("midreset_play_y", play_y, 32);
        chk("midreset_steps", step_count, 0);

        // Player 1 heads up to the top edge.
        tick_cycle(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 5'd0);
        tick_cycle(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 5'd0);
        n1 = 0; lx = -1; ly = -1; done = 1'b0;
        for (int k = 0; k < 1200 && !done; k++) begin
            idle_tick();
            if (super_enable === 1'b1 && play_num === 1'b0) begin
                n1++; lx = play_x; ly = play_y;
            end
            if (game_over === 1'b1 || n1 == 33) done = 1'b1;
        end
        if (!done) bound_fail("edge_run");
`ifdef ARENA_WRAP_EN
        chk("wrap_issues", n1, 33);
        chk("wrap_x", lx, 8);
        chk("wrap_y", ly, 63);
`else
        chk("edge_issues", n1, 32);
        chk("edge_winner", winner, 2);
        chk("edge_game_over", game_over, 1);
        chk("edge_steps", step_count, 32);
`endif

        // Randomized play against the model.
        tick_cycle(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 5'd0);
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 1999) == 0) do_reset();
            else tick_cycle($urandom_range(0, 39) == 0, 2'($urandom), $urandom_range(0, 7) == 0,
                            2'($urandom), $urandom_range(0, 7) == 0,
                            ($urandom_range(0, 29) == 0) ? 5'($urandom) : 5'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
